// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, port owners, word geometry.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBEAT  = 2'd1,
        RDRAIN = 2'd2,
        WBEAT  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BEAT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/mem_beat_counter.sv
// Beat counter for one word transfer; drives the byte address as base plus beat with wrap.
// Latency: address is combinational from the registered beat; counter advances one per cycle.
// Backpressure: none; clear wins over advance, so an aborted transfer restarts at beat 0.
module mem_beat_counter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [BEAT_W-1:0] beat_q;

    // Beat index: cleared between transfers, stepped once per issued beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else if (clear_i) begin
            beat_q <= '0;
        end else if (adv_i) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    assign beat_o = beat_q;
    assign last_o = (beat_q == BEAT_W'(BYTES_PER_WORD - 1));
    // Plain modular add: a base near the top of the address space rolls over to 0
    assign addr_o = base_i + ADDR_W'(beat_q);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one byte-wide memory port between fetch and load/store, moving each word as four beats.
// Latency: read request to response pulse 6 cycles, write request to d_done 5 cycles.
// Backpressure: requests are levels held until their pulse; contention resolved round-robin in IDLE.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [31:0]       if_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic              rd_pend_q;
    logic [BEAT_W-1:0] rd_lane_q;
    logic [31:0]       if_data_q;
    logic [31:0]       d_rdata_q;
    logic              if_valid_q;
    logic              d_done_q;

    logic [BEAT_W-1:0] beat;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_addr;
    logic              in_beat;
    logic              if_pulse;
    logic              if_req_m;
    logic              d_req_m;
    logic              kill;
    logic              grant_vld;
    owner_e            grant_own;

    // A visible response pulse masks its own requester so a still-high req is not regranted
    assign if_pulse = if_valid_q & ~if_flush;
    assign if_req_m = if_req & ~if_pulse;
    assign d_req_m  = d_req & ~d_done_q;
    assign in_beat  = (state_q == RBEAT) || (state_q == WBEAT);
    // Flush only aborts fetch-owned reads; data transfers run to completion
    assign kill     = if_flush && (owner_q == OWN_IF) &&
                      ((state_q == RBEAT) || (state_q == RDRAIN));

    // Round-robin grant: on contention the owner not granted last wins
    always_comb begin
        grant_vld = if_req_m | d_req_m;
        grant_own = OWN_IF;
        if (if_req_m && d_req_m) begin
            grant_own = (last_q == OWN_IF) ? OWN_D : OWN_IF;
        end else if (d_req_m) begin
            grant_own = OWN_D;
        end
    end

    mem_beat_counter #(
        .ADDR_W (ADDR_W)
    ) u_beat (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i ((state_q == IDLE) || kill),
        .adv_i   (in_beat),
        .base_i  (base_q),
        .beat_o  (beat),
        .last_o  (last_beat),
        .addr_o  (beat_addr)
    );

    // Transaction FSM with request capture, byte assembly and registered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            last_q     <= OWN_IF;
            base_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_lane_q  <= '0;
            if_data_q  <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_done_q   <= 1'b0;
            // Read data arrives one cycle after issue, so remember which lane it belongs to
            rd_pend_q  <= (state_q == RBEAT) && !kill;
            rd_lane_q  <= beat;
            if (rd_pend_q && !kill) begin
                asm_q[8*rd_lane_q +: 8] <= mem_rdata;
            end
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        owner_q <= grant_own;
                        last_q  <= grant_own;
                        base_q  <= (grant_own == OWN_IF) ? if_addr : d_addr;
                        wdata_q <= d_wdata;
                        state_q <= ((grant_own == OWN_D) && d_we) ? WBEAT : RBEAT;
                    end
                end
                RBEAT: begin
                    if (kill) begin
                        state_q <= IDLE;
                    end else if (last_beat) begin
                        state_q <= RDRAIN;
                    end
                end
                RDRAIN: begin
                    state_q <= IDLE;
                    if (!kill) begin
                        // Byte 3 is on mem_rdata now; merge it straight into the response
                        if (owner_q == OWN_IF) begin
                            if_data_q  <= {mem_rdata, asm_q[23:0]};
                            if_valid_q <= 1'b1;
                        end else begin
                            d_rdata_q  <= {mem_rdata, asm_q[23:0]};
                            d_done_q   <= 1'b1;
                        end
                    end
                end
                WBEAT: begin
                    if (last_beat) begin
                        state_q  <= IDLE;
                        d_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en    = in_beat;
    assign mem_we    = (state_q == WBEAT);
    assign mem_addr  = in_beat ? beat_addr : '0;
    assign mem_wdata = (state_q == WBEAT) ? wdata_q[8*beat +: 8] : 8'h00;
    assign if_valid  = if_pulse;
    assign if_data   = if_data_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
